// File: rtl/reg_file_sb.sv
// Register file with two asynchronous read ports, one write-back port and a per-register busy scoreboard.
// Define RF_BYPASS_EN to forward same-cycle write-back data and busy-clear to the read ports.
module reg_file_sb #(
   parameter int WIDTH    = 32,
   parameter int NUM_REGS = 32,
   parameter int ABITS    = 5,
   parameter int NPROT    = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [ABITS-1:0] rd_addr0,
   input  logic [ABITS-1:0] rd_addr1,
   output logic [WIDTH-1:0] rd_data0,
   output logic [WIDTH-1:0] rd_data1,
   output logic             rd_busy0,
   output logic             rd_busy1,
   input  logic             issue_vld,
   input  logic [ABITS-1:0] issue_dst,
   input  logic             wb_vld,
   input  logic [ABITS-1:0] wb_addr,
   input  logic [WIDTH-1:0] wb_data,
   output logic [ABITS:0]   busy_cnt
);

   localparam int             NWR   = NUM_REGS - NPROT;
   localparam logic [ABITS:0] NWR_A = NWR[ABITS:0];

   logic [WIDTH-1:0]    regs_r [NUM_REGS];
   logic [NUM_REGS-1:0] busy_r;
   logic [NUM_REGS-1:0] busy_nxt_s;
   logic [ABITS:0]      busy_cnt_r;
   logic [ABITS:0]      cnt_nxt_s;
   logic                wb_ok_s;
   logic                iss_ok_s;

   // Register 0 and the protected top registers never accept writes or producers.
   function automatic logic writable(input logic [ABITS-1:0] a);
      return (a != {ABITS{1'b0}}) && ({1'b0, a} < NWR_A);
   endfunction

   // Qualify issue and write-back against the writable range.
   always_comb begin
      wb_ok_s  = wb_vld && writable(wb_addr);
      iss_ok_s = issue_vld && writable(issue_dst);
   end

   // Next scoreboard state; a new producer outranks a same-cycle write-back.
   always_comb begin
      busy_nxt_s = busy_r;
      cnt_nxt_s  = {(ABITS+1){1'b0}};
      for (int i = 0; i < NUM_REGS; i++) begin
         busy_nxt_s[i] = (iss_ok_s && (issue_dst == ABITS'(i))) ? 1'b1 :
                         (wb_ok_s  && (wb_addr   == ABITS'(i))) ? 1'b0 : busy_r[i];
         cnt_nxt_s     = cnt_nxt_s + {{ABITS{1'b0}}, busy_nxt_s[i]};
      end
   end

   // State update; reset overrides any issue or write-back in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_r[i] <= {WIDTH{1'b0}};
         end
         busy_r     <= {NUM_REGS{1'b0}};
         busy_cnt_r <= {(ABITS+1){1'b0}};
      end else begin
         if (wb_ok_s) begin
            regs_r[wb_addr] <= wb_data;
         end
         busy_r     <= busy_nxt_s;
         busy_cnt_r <= cnt_nxt_s;
      end
   end

   assign busy_cnt = busy_cnt_r;

   // Read port 0.
   always_comb begin
      if (rd_addr0 == {ABITS{1'b0}}) begin
         rd_data0 = {WIDTH{1'b0}};
         rd_busy0 = 1'b0;
      end
`ifdef RF_BYPASS_EN
      else if (wb_ok_s && (rd_addr0 == wb_addr)) begin
         rd_data0 = wb_data;
         rd_busy0 = 1'b0;
      end
`endif
      else begin
         rd_data0 = regs_r[rd_addr0];
         rd_busy0 = busy_r[rd_addr0];
      end
   end

   // Read port 1.
   always_comb begin
      if (rd_addr1 == {ABITS{1'b0}}) begin
         rd_data1 = {WIDTH{1'b0}};
         rd_busy1 = 1'b0;
      end
`ifdef RF_BYPASS_EN
      else if (wb_ok_s && (rd_addr1 == wb_addr)) begin
         rd_data1 = wb_data;
         rd_busy1 = 1'b0;
      end
`endif
      else begin
         rd_data1 = regs_r[rd_addr1];
         rd_busy1 = busy_r[rd_addr1];
      end
   end

endmodule

// File: tb/tb_reg_file_sb.sv
// Randomised and directed self-checking bench for reg_file_sb against an array-based reference model.
module tb_reg_file_sb;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  rd_addr0, rd_addr1, issue_dst, wb_addr;
   logic [31:0] rd_data0, rd_data1, wb_data;
   logic        rd_busy0, rd_busy1, issue_vld, wb_vld;
   logic [5:0]  busy_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] m_regs [32];
   bit          m_busy [32];

   reg_file_sb #(.WIDTH(32), .NUM_REGS(32), .ABITS(5), .NPROT(5)) dut (
      .clk(clk), .rst(rst),
      .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
      .rd_data0(rd_data0), .rd_data1(rd_data1),
      .rd_busy0(rd_busy0), .rd_busy1(rd_busy1),
      .issue_vld(issue_vld), .issue_dst(issue_dst),
      .wb_vld(wb_vld), .wb_addr(wb_addr), .wb_data(wb_data),
      .busy_cnt(busy_cnt)
   );

   always #5 clk = ~clk;

   function automatic bit wr_ok(input logic [4:0] a);
      return (a != 5'd0) && (int'(a) < 27);
   endfunction

   function automatic logic [31:0] exp_data(input logic [4:0] a);
      if (a == 5'd0) return 32'd0;
`ifdef RF_BYPASS_EN
      if (wb_vld && wr_ok(wb_addr) && a == wb_addr) return wb_data;
`endif
      return m_regs[a];
   endfunction

   function automatic logic exp_busy(input logic [4:0] a);
`ifdef RF_BYPASS_EN
      if (wb_vld && wr_ok(wb_addr) && a == wb_addr) return 1'b0;
`endif
      return m_busy[a];
   endfunction

   function automatic logic [5:0] exp_cnt();
      int c = 0;
      for (int i = 0; i < 32; i++) c += int'(m_busy[i]);
      return 6'(c);
   endfunction

   task automatic drive(input logic r, input logic iv, input logic [4:0] id,
                        input logic wv, input logic [4:0] wa, input logic [31:0] wd,
                        input logic [4:0] a0, input logic [4:0] a1);
      rst = r; issue_vld = iv; issue_dst = id;
      wb_vld = wv; wb_addr = wa; wb_data = wd;
      rd_addr0 = a0; rd_addr1 = a1;
      #1;
   endtask

   // Advance one clock and apply the architectural rules to the model.
   task automatic tick();
      @(posedge clk);
      if (rst) begin
         for (int i = 0; i < 32; i++) begin m_regs[i] = 32'd0; m_busy[i] = 1'b0; end
      end else begin
         if (wb_vld && wr_ok(wb_addr)) begin m_regs[wb_addr] = wb_data; m_busy[wb_addr] = 1'b0; end
         if (issue_vld && wr_ok(issue_dst)) m_busy[issue_dst] = 1'b1;
      end
      #1;
   endtask

   task automatic test_reset();
      drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd3, 5'd3);
      tick(); tick();
      drive(1'b0, 1'b0, 5'd0, 1'b1, 5'd3, 32'hDEAD_BEEF, 5'd3, 5'd3);
      tick();
      drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd3, 5'd3);
      n_checks++; if (rd_data0 !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL reset_pre_write: got %h want DEADBEEF", rd_data0); end
      drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd3, 5'd3);
      tick();
      drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd3, 5'd3);
      n_checks++; if (rd_data0 !== 32'd0) begin n_fail++; $display("FAIL reset_data: got %h want 0", rd_data0); end
      n_checks++; if (rd_busy0 !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", rd_busy0); end
      n_checks++; if (busy_cnt !== 6'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", busy_cnt); end
   endtask

   task automatic test_protected();
      drive(1'b0, 1'b0, 5'd0, 1'b1, 5'd0, 32'h1234, 5'd0, 5'd30);
      tick();
      drive(1'b0, 1'b0, 5'd0, 1'b1, 5'd30, 32'h5555, 5'd0, 5'd30);
      tick();
      drive(1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd30);
      n_checks++; if (rd_data0 !== 32'd0) begin n_fail++; $display("FAIL prot_r0: got %h want 0", rd_data0); end
      n_checks++; if (rd_data1 !== 32'd0) begin n_fail++; $display("FAIL prot_r30: got %h want 0", rd_data1); end
      tick();
      drive(1'b0, 1'b1, 5'd30, 1'b0, 5'd0, 32'd0, 5'd0, 5'd30);
      tick();
      drive(1'b0, 1'b1, 5'd27, 1'b0, 5'd0, 32'd0, 5'd27, 5'd30);
      tick();
      drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd27, 5'd30);
      n_checks++; if (busy_cnt !== 6'd0) begin n_fail++; $display("FAIL prot_cnt: got %0d want 0", busy_cnt); end
      n_checks++; if (rd_busy1 !== 1'b0) begin n_fail++; $display("FAIL prot_busy30: got %b want 0", rd_busy1); end
   endtask

   task automatic test_scoreboard();
      drive(1'b0, 1'b1, 5'd5, 1'b0, 5'd0, 32'd0, 5'd5, 5'd7);
      tick();
      drive(1'b0, 1'b1, 5'd7, 1'b0, 5'd0, 32'd0, 5'd5, 5'd7);
      tick();
      drive(1'b0, 1'b1, 5'd7, 1'b0, 5'd0, 32'd0, 5'd5, 5'd7);
      tick();
      drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd7);
      n_checks++; if (busy_cnt !== 6'd2) begin n_fail++; $display("FAIL sb_cnt2: got %0d want 2", busy_cnt); end
      n_checks++; if (rd_busy0 !== 1'b1) begin n_fail++; $display("FAIL sb_busy5: got %b want 1", rd_busy0); end
      drive(1'b0, 1'b0, 5'd0, 1'b1, 5'd5, 32'hA5, 5'd6, 5'd7);
      tick();
      drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd7);
      n_checks++; if (rd_busy0 !== 1'b0) begin n_fail++; $display("FAIL sb_clear5: got %b want 0", rd_busy0); end
      n_checks++; if (busy_cnt !== 6'd1) begin n_fail++; $display("FAIL sb_cnt1: got %0d want 1", busy_cnt); end
      n_checks++; if (rd_data0 !== 32'hA5) begin n_fail++; $display("FAIL sb_data5: got %h want A5", rd_data0); end
      n_checks++; if (rd_busy1 !== 1'b1) begin n_fail++; $display("FAIL sb_busy7: got %b want 1", rd_busy1); end
   endtask

   task automatic test_collision();
      drive(1'b0, 1'b1, 5'd9, 1'b0, 5'd0, 32'd0, 5'd9, 5'd9);
      tick();
      drive(1'b0, 1'b1, 5'd9, 1'b1, 5'd9, 32'h77, 5'd1, 5'd1);
      tick();
      drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd9, 5'd9);
      n_checks++; if (rd_data0 !== 32'h77) begin n_fail++; $display("FAIL coll_data: got %h want 77", rd_data0); end
      n_checks++; if (rd_busy0 !== 1'b1) begin n_fail++; $display("FAIL coll_busy: got %b want 1", rd_busy0); end
      n_checks++; if (busy_cnt !== 6'd2) begin n_fail++; $display("FAIL coll_cnt: got %0d want 2", busy_cnt); end
   endtask

   task automatic test_bypass();
      logic [31:0] exp_same;
      logic        exp_b;
      drive(1'b0, 1'b0, 5'd0, 1'b1, 5'd4, 32'h1111, 5'd0, 5'd0);
      tick();
      drive(1'b0, 1'b0, 5'd0, 1'b1, 5'd4, 32'hCAFE, 5'd4, 5'd4);
`ifdef RF_BYPASS_EN
      exp_same = 32'hCAFE;
`else
      exp_same = 32'h1111;
`endif
      n_checks++; if (rd_data0 !== exp_same) begin n_fail++; $display("FAIL byp_p0: got %h want %h", rd_data0, exp_same); end
      n_checks++; if (rd_data1 !== exp_same) begin n_fail++; $display("FAIL byp_p1: got %h want %h", rd_data1, exp_same); end
      tick();
      drive(1'b0, 1'b1, 5'd9, 1'b1, 5'd9, 32'h99, 5'd4, 5'd9);
      n_checks++; if (rd_data0 !== 32'hCAFE) begin n_fail++; $display("FAIL byp_next: got %h want CAFE", rd_data0); end
`ifdef RF_BYPASS_EN
      exp_same = 32'h99; exp_b = 1'b0;
`else
      exp_same = 32'h77; exp_b = 1'b1;
`endif
      n_checks++; if (rd_data1 !== exp_same) begin n_fail++; $display("FAIL byp_coll_data: got %h want %h", rd_data1, exp_same); end
      n_checks++; if (rd_busy1 !== exp_b) begin n_fail++; $display("FAIL byp_coll_busy: got %b want %b", rd_busy1, exp_b); end
      tick();
      drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd4, 5'd9);
      n_checks++; if (rd_data1 !== 32'h99 || rd_busy1 !== 1'b1) begin n_fail++; $display("FAIL byp_after: got %h/%b want 99/1", rd_data1, rd_busy1); end
   endtask

   task automatic test_reset_midop();
      drive(1'b1, 1'b1, 5'd10, 1'b1, 5'd10, 32'hBAD, 5'd10, 5'd4);
      tick();
      drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd10, 5'd4);
      n_checks++; if (rd_data0 !== 32'd0 || rd_busy0 !== 1'b0) begin n_fail++; $display("FAIL midrst_r10: got %h/%b want 0/0", rd_data0, rd_busy0); end
      n_checks++; if (rd_data1 !== 32'd0) begin n_fail++; $display("FAIL midrst_r4: got %h want 0", rd_data1); end
      n_checks++; if (busy_cnt !== 6'd0) begin n_fail++; $display("FAIL midrst_cnt: got %0d want 0", busy_cnt); end
   endtask

   task automatic test_random();
      int nprint = 0;
      for (int k = 0; k < 600; k++) begin
         drive(($urandom_range(0, 59) == 0),
               1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
               1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31)),
               $urandom(),
               5'($urandom_range(0, 31)), ($urandom_range(0, 3) == 0) ? wb_addr : 5'($urandom_range(0, 31)));
         if (($urandom_range(0, 3) == 0)) begin rd_addr0 = wb_addr; #1; end
         n_checks++;
         if (rd_data0 !== exp_data(rd_addr0) || rd_busy0 !== exp_busy(rd_addr0)) begin
            n_fail++;
            if (nprint++ < 10) $display("FAIL rnd_port0 a=%0d: got %h/%b want %h/%b", rd_addr0, rd_data0, rd_busy0, exp_data(rd_addr0), exp_busy(rd_addr0));
         end
         n_checks++;
         if (rd_data1 !== exp_data(rd_addr1) || rd_busy1 !== exp_busy(rd_addr1)) begin
            n_fail++;
            if (nprint++ < 10) $display("FAIL rnd_port1 a=%0d: got %h/%b want %h/%b", rd_addr1, rd_data1, rd_busy1, exp_data(rd_addr1), exp_busy(rd_addr1));
         end
         n_checks++;
         if (busy_cnt !== exp_cnt()) begin
            n_fail++;
            if (nprint++ < 10) $display("FAIL rnd_cnt: got %0d want %0d", busy_cnt, exp_cnt());
         end
         tick();
      end
   endtask

   initial begin
      for (int i = 0; i < 32; i++) begin m_regs[i] = 32'd0; m_busy[i] = 1'b0; end
      test_reset();
      test_protected();
      test_scoreboard();
      test_collision();
      test_bypass();
      test_reset_midop();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
